// File: rtl/bitty_mem_arbiter_if.sv
// bitty_mem_arbiter_if: request/grant/read-response bundle for one memory master
interface bitty_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] be;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/bitty_mem_arbiter.sv
// bitty_mem_arbiter: round-robin two-master arbiter with hold limit for the single-port data RAM
module bitty_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 2
) (
  input  logic                clk,
  input  logic                rst,
  bitty_mem_arbiter_if.slave  m0,
  bitty_mem_arbiter_if.slave  m1,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic          rr_ptr;
  logic          owner;
  logic          rd_pend;
  logic [CW-1:0] hold_cnt;
  logic          both;
  logic          any;
  logic          sel;
  // pick the winner, drive grants and the RAM bus, route the pending read response
  always_comb begin
    both      = m0.req & m1.req;
    any       = rst & (m0.req | m1.req);
    sel       = both ? rr_ptr : ~m0.req;
    m0.gnt    = any & ~sel;
    m1.gnt    = any & sel;
    mem_ce    = any;
    mem_we    = any & (sel ? m1.we : m0.we);
    mem_addr  = any ? (sel ? m1.addr : m0.addr) : '0;
    mem_wdata = any ? (sel ? m1.wdata : m0.wdata) : '0;
    mem_be    = any ? (sel ? m1.be : m0.be) : '0;
    m0.rvalid = rd_pend & ~owner;
    m1.rvalid = rd_pend & owner;
    m0.rdata  = (rd_pend & ~owner) ? mem_rdata : '0;
    m1.rdata  = (rd_pend & owner) ? mem_rdata : '0;
  end
  // track read ownership and the round-robin pointer with its contention hold count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      rd_pend  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      rd_pend <= any & ~mem_we;
      if (any & ~mem_we) owner <= sel;
      if (any) begin
        if (both) begin
          if (hold_cnt + CW'(1) == CW'(HOLD_MAX)) begin
            rr_ptr   <= ~sel;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end else begin
          rr_ptr   <= sel;
          hold_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_bitty_mem_arbiter.sv
// tb_bitty_mem_arbiter: vector table, directed corner cases and random traffic against a reference model
module tb_bitty_mem_arbiter;
  logic clk = 1'b1;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  bitty_mem_arbiter_if m0 ();
  bitty_mem_arbiter_if m1 ();
  bitty_mem_arbiter_if n0 ();
  bitty_mem_arbiter_if n1 ();
  logic        mem_ce, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        n_ce, n_we;
  logic [31:0] n_addr, n_wdata;
  logic [3:0]  n_be;
  assign n0.req = m0.req;
  assign n0.we = m0.we;
  assign n0.addr = m0.addr;
  assign n0.wdata = m0.wdata;
  assign n0.be = m0.be;
  assign n1.req = m1.req;
  assign n1.we = m1.we;
  assign n1.addr = m1.addr;
  assign n1.wdata = m1.wdata;
  assign n1.be = m1.be;
  bitty_mem_arbiter #(.HOLD_MAX(2)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );
  bitty_mem_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .m0(n0), .m1(n1),
    .mem_ce(n_ce), .mem_we(n_we), .mem_addr(n_addr),
    .mem_wdata(n_wdata), .mem_be(n_be), .mem_rdata(32'h0)
  );
  logic [31:0] ram [256];
  always @(posedge clk)
    if (mem_ce) begin
      if (mem_we) begin
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) ram[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  int checks = 0;
  int errors = 0;
  int hold [2] = '{2, 1};
  int pref [2];
  int streak [2];
  int pend [2];
  logic [31:0] pdata;
  logic [31:0] emem [256];
  typedef struct { bit r0, r1, g0, g1, h0, h1; } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int win(input int k);
    if (!rst) return -1;
    if (m0.req && m1.req) return pref[k];
    if (m0.req) return 0;
    if (m1.req) return 1;
    return -1;
  endfunction
  function automatic logic [31:0] pick(input int w, input logic [31:0] a, input logic [31:0] b);
    return w == 0 ? a : w == 1 ? b : 32'h0;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pref[k] = 0;
      streak[k] = 0;
      pend[k] = -1;
    end
  endtask
  task automatic model_check();
    int w = win(0);
    int v = win(1);
    chk1("gnt0", m0.gnt, w == 0);
    chk1("gnt1", m1.gnt, w == 1);
    chk1("mem_ce", mem_ce, w >= 0);
    chk1("mem_we", mem_we, pick(w, 32'(m0.we), 32'(m1.we)) != 0);
    chk("mem_addr", mem_addr, pick(w, m0.addr, m1.addr));
    chk("mem_wdata", mem_wdata, pick(w, m0.wdata, m1.wdata));
    chk("mem_be", 32'(mem_be), pick(w, 32'(m0.be), 32'(m1.be)));
    chk1("rvalid0", m0.rvalid, pend[0] == 0);
    chk1("rvalid1", m1.rvalid, pend[0] == 1);
    chk("rdata0", m0.rdata, pend[0] == 0 ? pdata : 32'h0);
    chk("rdata1", m1.rdata, pend[0] == 1 ? pdata : 32'h0);
    chk1("h1_gnt0", n0.gnt, v == 0);
    chk1("h1_gnt1", n1.gnt, v == 1);
    chk1("h1_rvalid0", n0.rvalid, pend[1] == 0);
    chk1("h1_rvalid1", n1.rvalid, pend[1] == 1);
  endtask
  task automatic model_update();
    bit both = m0.req && m1.req;
    for (int k = 0; k < 2; k++) begin
      int w = win(k);
      bit rd = (w == 0) ? !m0.we : (w == 1) ? !m1.we : 1'b0;
      pend[k] = rd ? w : -1;
      if (k == 0 && w >= 0) begin
        logic [31:0] a = pick(w, m0.addr, m1.addr);
        logic [31:0] d = pick(w, m0.wdata, m1.wdata);
        logic [31:0] b = pick(w, 32'(m0.be), 32'(m1.be));
        if (rd) pdata = emem[a[9:2]];
        else for (int i = 0; i < 4; i++) if (b[i]) emem[a[9:2]][8*i +: 8] = d[8*i +: 8];
      end
      if (w >= 0) begin
        if (both) begin
          streak[k]++;
          if (streak[k] == hold[k]) begin
            pref[k] = 1 - w;
            streak[k] = 0;
          end
        end else begin
          pref[k] = w;
          streak[k] = 0;
        end
      end
    end
  endtask
  task automatic settle();
    @(negedge clk);
    model_check();
  endtask
  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    m0.req = r0; m0.we = w0; m0.addr = a0; m0.wdata = d0; m0.be = 4'hF;
    m1.req = r1; m1.we = w1; m1.addr = a1; m1.wdata = d1; m1.be = 4'hF;
  endtask
  initial begin
    bit held0, held1;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 32'h0;
      emem[i] = 32'h0;
    end
    model_reset();
    pdata = 32'h0;
    for (int i = 0; i < 8; i++) tbl[i] = '{1, 1, (i % 4) < 2, (i % 4) >= 2, (i % 2) == 0, (i % 2) == 1};
    tbl[8]  = '{0, 1, 0, 1, 0, 1};
    tbl[9]  = '{1, 1, 0, 1, 0, 1};
    tbl[10] = '{1, 1, 0, 1, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0};
    drv(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (19) begin
      settle();
      @(posedge clk);
    end
    #5 rst = 1'b1;
    #1 model_check();
    chk1("rst_first_gnt", m0.gnt, 1'b1);
    advance();
    drv(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    settle();
    chk1("sm_wr_gnt", m0.gnt, 1'b1);
    advance();
    drv(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    settle();
    chk1("sm_rd_gnt", m0.gnt, 1'b1);
    advance();
    drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    settle();
    chk1("sm_rvalid0", m0.rvalid, 1'b1);
    chk("sm_rdata0", m0.rdata, 32'hDEADBEEF);
    chk1("sm_rvalid1", m1.rvalid, 1'b0);
    advance();
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].r0, 0, 32'h40 + 32'(4 * i), 32'h0, tbl[i].r1, 0, 32'h80 + 32'(4 * i), 32'h0);
      settle();
      chk1($sformatf("tbl%0d_gnt0", i), m0.gnt, tbl[i].g0);
      chk1($sformatf("tbl%0d_gnt1", i), m1.gnt, tbl[i].g1);
      chk1($sformatf("tbl%0d_h1_gnt0", i), n0.gnt, tbl[i].h0);
      chk1($sformatf("tbl%0d_h1_gnt1", i), n1.gnt, tbl[i].h1);
      advance();
    end
    drv(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
    settle();
    advance();
    drv(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    settle();
    chk1("b2b_rd_gnt1", m1.gnt, 1'b1);
    advance();
    drv(1, 1, 32'h24, 32'hCAFE0001, 0, 0, 32'h0, 32'h0);
    settle();
    chk1("b2b_rvalid1", m1.rvalid, 1'b1);
    chk("b2b_rdata1", m1.rdata, 32'h12345678);
    chk1("b2b_ce", mem_ce, 1'b1);
    chk1("b2b_we", mem_we, 1'b1);
    chk("b2b_addr", mem_addr, 32'h24);
    chk1("b2b_rvalid0", m0.rvalid, 1'b0);
    advance();
    drv(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0);
    settle();
    advance();
    #2 model_check();
    chk1("mr_gnt0", m0.gnt, 1'b1);
    #4 rst = 1'b0;
    model_reset();
    #1 model_check();
    settle();
    rst = 1'b1;
    #1 model_check();
    chk1("mr_rvalid0", m0.rvalid, 1'b0);
    chk1("mr_rr_ptr", m0.gnt, 1'b1);
    advance();
    settle();
    chk1("mr_hold_cnt", m0.gnt, 1'b1);
    advance();
    held0 = 0;
    held1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (held0) begin
        if ($urandom_range(0, 7) == 0) m0.req = 1'b0;
      end else begin
        m0.req = $urandom_range(0, 2) != 0;
        m0.we = 1'($urandom);
        m0.addr = {26'h0, 4'($urandom), 2'b00};
        m0.wdata = $urandom;
        m0.be = 4'($urandom);
      end
      if (held1) begin
        if ($urandom_range(0, 7) == 0) m1.req = 1'b0;
      end else begin
        m1.req = $urandom_range(0, 2) != 0;
        m1.we = 1'($urandom);
        m1.addr = {26'h0, 4'($urandom), 2'b00};
        m1.wdata = $urandom;
        m1.be = 4'($urandom);
      end
      settle();
      held0 = m0.req && !m0.gnt;
      held1 = m1.req && !m1.gnt;
      advance();
    end
    drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    settle();
    advance();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
